// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute stage: opcodes, FSM state encoding
// and default widths.
package alu_pkg;

  localparam int unsigned DATA_W_DFLT = 32;
  localparam int unsigned OP_W_DFLT   = 4;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SHL   = 4'd5;
  localparam logic [3:0] OP_SHR   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_SLT   = 4'd8;
  localparam logic [3:0] OP_MUL   = 4'd9;
  localparam logic [3:0] OP_PASSB = 4'd10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial product per cycle, DATA_W
// cycles per operation; done/product are valid in the final busy cycle.
module alu_mul_seq #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              iClk,
  input  logic              iReset,
  input  logic              iStart,
  input  logic [DATA_W-1:0] iA,
  input  logic [DATA_W-1:0] iB,
  output logic              oBusy,
  output logic              oDone_c,
  output logic [DATA_W-1:0] oProduct_c
);

  localparam int unsigned CNT_W = $clog2(DATA_W);

  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              last_c;

  assign last_c     = busy_q && (cnt_q == CNT_W'(DATA_W - 1));
  assign oBusy      = busy_q;
  assign oDone_c    = last_c;
  assign oProduct_c = acc_d;

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (iStart) begin
      a_d    = iA;
      b_d    = iB;
      acc_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      acc_d  = acc_q + (b_q[0] ? a_q : '0);
      a_d    = a_q << 1;
      b_d    = b_q >> 1;
      cnt_d  = cnt_q + CNT_W'(1);
      busy_d = !last_c;
    end
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/alu_exec_stage.sv
// ALU execute stage: single-cycle combinational ops plus an iterative MUL,
// registered result/flags, valid/ready handshake on both sides.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DFLT,
  parameter int unsigned OP_W    = OP_W_DFLT,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic              iClk,
  input  logic              iReset,
  input  logic              iValid,
  output logic              oReady,
  input  logic [DATA_W-1:0] iSrcA,
  input  logic [DATA_W-1:0] iSrcB,
  input  logic [OP_W-1:0]   iOp,
  output logic              oValid,
  input  logic              iReady,
  output logic [DATA_W-1:0] oResult,
  output logic              oZero,
  output logic              oNeg,
  output logic              oCarry,
  output logic              oOvf,
  output logic              oIllegal
);

  state_e            state_q, state_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              zero_q, zero_d, neg_q, neg_d;
  logic              carry_q, carry_d, ovf_q, ovf_d, ill_q, ill_d;

  logic              accept_c, is_mul_c;
  logic              mul_busy, mul_done_c;
  logic [DATA_W-1:0] mul_prod_c;
  logic [DATA_W:0]   sum_c, diff_c;
  logic [SHAMT_W-1:0] shamt_c;
  logic [DATA_W-1:0] alu_res_c;
  logic              alu_carry_c, alu_ovf_c, alu_ill_c;

  assign oReady   = !iReset && (state_q == ST_IDLE) && !mul_busy && (!valid_q || iReady);
  assign accept_c = iValid && oReady;
  assign is_mul_c = (iOp == OP_W'(OP_MUL));
  assign sum_c    = {1'b0, iSrcA} + {1'b0, iSrcB};
  assign diff_c   = {1'b0, iSrcA} - {1'b0, iSrcB};
  assign shamt_c  = iSrcB[SHAMT_W-1:0];

  alu_mul_seq #(.DATA_W(DATA_W)) u_mul (
    .iClk       (iClk),
    .iReset     (iReset),
    .iStart     (accept_c && is_mul_c),
    .iA         (iSrcA),
    .iB         (iSrcB),
    .oBusy      (mul_busy),
    .oDone_c    (mul_done_c),
    .oProduct_c (mul_prod_c)
  );

  // Single-cycle datapath; carry on SUB means no borrow.
  always_comb begin
    alu_res_c   = '0;
    alu_carry_c = 1'b0;
    alu_ovf_c   = 1'b0;
    alu_ill_c   = 1'b0;
    case (iOp)
      OP_W'(OP_ADD): begin
        alu_res_c   = sum_c[DATA_W-1:0];
        alu_carry_c = sum_c[DATA_W];
        alu_ovf_c   = (iSrcA[DATA_W-1] == iSrcB[DATA_W-1]) &&
                      (sum_c[DATA_W-1] != iSrcA[DATA_W-1]);
      end
      OP_W'(OP_SUB): begin
        alu_res_c   = diff_c[DATA_W-1:0];
        alu_carry_c = !diff_c[DATA_W];
        alu_ovf_c   = (iSrcA[DATA_W-1] != iSrcB[DATA_W-1]) &&
                      (diff_c[DATA_W-1] != iSrcA[DATA_W-1]);
      end
      OP_W'(OP_AND):   alu_res_c = iSrcA & iSrcB;
      OP_W'(OP_OR):    alu_res_c = iSrcA | iSrcB;
      OP_W'(OP_XOR):   alu_res_c = iSrcA ^ iSrcB;
      OP_W'(OP_SHL):   alu_res_c = iSrcA << shamt_c;
      OP_W'(OP_SHR):   alu_res_c = iSrcA >> shamt_c;
      OP_W'(OP_SRA):   alu_res_c = $unsigned($signed(iSrcA) >>> shamt_c);
      OP_W'(OP_SLT):   alu_res_c = DATA_W'($signed(iSrcA) < $signed(iSrcB));
      OP_W'(OP_MUL):   alu_res_c = '0;
      OP_W'(OP_PASSB): alu_res_c = iSrcB;
      default:         alu_ill_c = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    res_d   = res_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    ill_d   = ill_q;
    if (valid_q && iReady) begin
      valid_d = 1'b0;
    end
    case (state_q)
      ST_IDLE: begin
        if (accept_c && is_mul_c) begin
          state_d = ST_MUL;
          valid_d = 1'b0;
        end else if (accept_c) begin
          valid_d = 1'b1;
          res_d   = alu_res_c;
          zero_d  = (alu_res_c == '0);
          neg_d   = alu_res_c[DATA_W-1];
          carry_d = alu_carry_c;
          ovf_d   = alu_ovf_c;
          ill_d   = alu_ill_c;
        end
      end
      ST_MUL: begin
        if (mul_done_c) begin
          state_d = ST_IDLE;
          valid_d = 1'b1;
          res_d   = mul_prod_c;
          zero_d  = (mul_prod_c == '0);
          neg_d   = mul_prod_c[DATA_W-1];
          carry_d = 1'b0;
          ovf_d   = 1'b0;
          ill_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      ill_q   <= ill_d;
    end
  end

  assign oValid   = valid_q;
  assign oResult  = res_q;
  assign oZero    = zero_q;
  assign oNeg     = neg_q;
  assign oCarry   = carry_q;
  assign oOvf     = ovf_q;
  assign oIllegal = ill_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed-vector bench for alu_exec_stage with hand-computed expectations.
module tb_alu_exec_stage;

  logic        iClk = 1'b0;
  logic        iReset, iValid, oReady, oValid, iReady;
  logic [31:0] iSrcA, iSrcB, oResult;
  logic [3:0]  iOp;
  logic        oZero, oNeg, oCarry, oOvf, oIllegal;

  int n_checks = 0;
  int n_errors = 0;

  always #5 iClk = ~iClk;

  alu_exec_stage dut (
    .iClk(iClk), .iReset(iReset), .iValid(iValid), .oReady(oReady),
    .iSrcA(iSrcA), .iSrcB(iSrcB), .iOp(iOp), .oValid(oValid),
    .iReady(iReady), .oResult(oResult), .oZero(oZero), .oNeg(oNeg),
    .oCarry(oCarry), .oOvf(oOvf), .oIllegal(oIllegal)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  // flags packed as {Z,N,C,V}
  function automatic logic [31:0] flags();
    return 32'({oZero, oNeg, oCarry, oOvf});
  endfunction

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    iOp = op; iSrcA = a; iSrcB = b; iValid = 1'b1;
    step();
    iValid = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, res;
    logic [3:0]  fl;
  } vec_t;

  vec_t stream_v[4];
  vec_t shift_v[3];
  logic saw_valid;

  initial begin
    iReset = 1'b1; iValid = 1'b0; iReady = 1'b1;
    iSrcA = '0; iSrcB = '0; iOp = '0;
    step(); step();
    chk("rst_valid", 32'(oValid), 32'd0);
    chk("rst_result", oResult, 32'd0);
    chk("rst_flags", flags(), 32'd0);
    chk("rst_illegal", 32'(oIllegal), 32'd0);
    chk("rst_ready_low", 32'(oReady), 32'd0);
    iReset = 1'b0; #1;
    chk("ready_after_rst", 32'(oReady), 32'd1);

    // ADD with the call constant
    issue(4'd0, 32'd5, 32'hFFFF_FFFF);
    chk("add_valid", 32'(oValid), 32'd1);
    chk("add_result", oResult, 32'd4);
    chk("add_flags", flags(), 32'b0010);

    issue(4'd1, 32'h8000_0000, 32'd1);
    chk("sub_result", oResult, 32'h7FFF_FFFF);
    chk("sub_flags", flags(), 32'b0011);

    // MUL: 32 busy cycles, result after edge N+32
    issue(4'd9, 32'h0001_0003, 32'd7);
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("mul_busy_%0d", i), {30'd0, oReady, oValid}, 32'd0);
      step();
    end
    chk("mul_valid", 32'(oValid), 32'd1);
    chk("mul_result", oResult, 32'h0007_0015);
    chk("mul_flags", flags(), 32'b0000);
    chk("mul_ready_after", 32'(oReady), 32'd1);

    // MUL aborted by reset at edge M+10
    issue(4'd9, 32'd3, 32'd3);
    repeat (9) step();
    iReset = 1'b1;
    step();
    chk("abort_ready_in_rst", 32'(oReady), 32'd0);
    iReset = 1'b0; #1;
    chk("abort_ready", 32'(oReady), 32'd1);
    chk("abort_valid", 32'(oValid), 32'd0);
    saw_valid = 1'b0;
    repeat (40) begin
      step();
      if (oValid) saw_valid = 1'b1;
    end
    chk("abort_no_result", 32'(saw_valid), 32'd0);

    // Backpressure: held output, new iValid ignored
    iReady = 1'b0;
    issue(4'd7, 32'hF000_0000, 32'd4);
    iOp = 4'd0; iSrcA = 32'd1; iSrcB = 32'd1; iValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp_result_%0d", i), oResult, 32'hFF00_0000);
      chk($sformatf("bp_vr_%0d", i), {30'd0, oReady, oValid}, 32'b01);
      step();
    end
    chk("bp_flags", flags(), 32'b0100);
    iValid = 1'b0;
    iReady = 1'b1; #1;
    chk("bp_release_ready", 32'(oReady), 32'd1);
    step();
    chk("bp_consumed", 32'(oValid), 32'd0);

    // Streaming, one result per cycle
    stream_v[0] = '{4'd2, 32'hFFFF_FFFF, 32'd1, 32'd1,           4'b0000};
    stream_v[1] = '{4'd3, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF,   4'b0100};
    stream_v[2] = '{4'd4, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE,   4'b0100};
    stream_v[3] = '{4'd8, 32'hFFFF_FFFF, 32'd1, 32'd1,           4'b0000};
    for (int i = 0; i < 4; i++) begin
      iOp = stream_v[i].op; iSrcA = stream_v[i].a; iSrcB = stream_v[i].b;
      iValid = 1'b1;
      step();
      chk($sformatf("stream_valid_%0d", i), 32'(oValid), 32'd1);
      chk($sformatf("stream_result_%0d", i), oResult, stream_v[i].res);
      chk($sformatf("stream_flags_%0d", i), flags(), 32'(stream_v[i].fl));
    end
    iValid = 1'b0;

    // Shift boundaries: amount 0 via B=32, max amount 31
    shift_v[0] = '{4'd5, 32'h0000_ABCD, 32'd32, 32'h0000_ABCD, 4'b0000};
    shift_v[1] = '{4'd5, 32'd1,         32'd31, 32'h8000_0000, 4'b0100};
    shift_v[2] = '{4'd6, 32'h8000_0000, 32'd31, 32'd1,         4'b0000};
    for (int i = 0; i < 3; i++) begin
      issue(shift_v[i].op, shift_v[i].a, shift_v[i].b);
      chk($sformatf("shift_result_%0d", i), oResult, shift_v[i].res);
      chk($sformatf("shift_flags_%0d", i), flags(), 32'(shift_v[i].fl));
    end

    // Undefined opcode, then recovery
    issue(4'd15, 32'h1234_5678, 32'h9ABC_DEF0);
    chk("ill_result", oResult, 32'd0);
    chk("ill_flag", 32'(oIllegal), 32'd1);
    chk("ill_flags", flags(), 32'b1000);
    issue(4'd10, 32'd0, 32'h0000_1234);
    chk("passb_illegal", 32'(oIllegal), 32'd0);
    chk("passb_result", oResult, 32'h0000_1234);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
